ram64_loader: RTL and testbench
===============================

// Module: ram64_loader
// PURPOSE
//   Boot/DMA write stage sitting directly upstream of the 64-word RAM: owns the
//   RAM's address/in/load inputs. When idle it passes CPU accesses straight through;
//   on start it streams a block of 16-bit words from a valid/ready source into
//   consecutive RAM addresses, accumulating a 16-bit checksum, then pulses done.
// PARAMETERS
//   none (width fixed at 16-bit data, 6-bit address, matching the RAM64 stage)
// PORTS
//   clk          in   1   system clock, all state updates on rising edge
//   rst_n        in   1   synchronous reset, active-low
//   start        in   1   begin a load burst (sampled only in IDLE)
//   base         in   6   first RAM address of the burst (sampled with start)
//   count        in   7   number of words to write, 0..64 (sampled with start)
//   in_valid     in   1   source has a word on in_data
//   in_data      in   16  word to write
//   in_ready     out  1   loader accepts in_data this cycle
//   cpu_address  in   6   CPU-side address
//   cpu_in       in   16  CPU-side write data
//   cpu_load     in   1   CPU-side write enable
//   cpu_stall    out  1   1 while a burst owns the RAM
//   ram_address  out  6   to RAM address
//   ram_in       out  16  to RAM in
//   ram_load     out  1   to RAM load
//   busy         out  1   burst in progress (LOAD state)
//   done         out  1   one-cycle pulse at end of burst
//   checksum     out  16  sum mod 2^16 of words written in last/current burst
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): state=IDLE, index=0, remaining=0, checksum=0,
//   done=0; thus busy=0, in_ready=0, cpu_stall=0. Words already written stay in RAM.
// - States: IDLE, LOAD, DONE.
//   IDLE: ram_* = cpu_* combinationally. start=1 -> capture base, count; clear
//     checksum and index; count==0 -> DONE, else -> LOAD. Values 65..127 saturate to 64.
//   LOAD: busy=1, cpu_stall=1, in_ready=1; ram_address = base+index (mod 64, wraps
//     63->0); ram_in = in_data; ram_load = in_valid. cpu_load is dropped, not queued.
//     Beat = in_valid & in_ready: the RAM writes on that same edge (0 added
//     latency); index+1, remaining-1, checksum += in_data (carry discarded).
//     Beat with remaining==1 -> DONE. in_valid=0 -> hold, no write.
//   DONE: done=1 for exactly this cycle, in_ready=0, ram_* = cpu_* again,
//     cpu_stall=0; -> IDLE unconditionally. start here is ignored.
// - start while in LOAD or DONE is ignored; base/count changes are ignored after capture.
// - checksum holds its value in IDLE until the next accepted start.
// - Reset mid-burst aborts at once: no done pulse, partial writes remain.
// - Everything outside LOAD (except done in DONE) is a pure passthrough: no added
//   cycle on CPU accesses.
// TESTING
// 1 Reset: rst_n=0 for 2 cycles with start=1 -> busy=0,done=0,checksum=0,in_ready=0.
// 2 Passthrough: IDLE, cpu_address=5,cpu_in=16'h1234,cpu_load=1 -> ram_* mirror,
//   RAM[5]=16'h1234 next cycle.
// 3 Burst: base=10,count=3, words 1,2,3 back-to-back -> RAM[10..12]=1,2,3, done
//   pulses 1 cycle after 3rd beat, checksum=6, burst takes 3 beat cycles.
// 4 Wrap+stall: base=62,count=4, in_valid gapped (1,0,1,0,...) -> writes to 62,63,0,1
//   only on valid cycles; cpu_load=1 during burst leaves RAM[cpu_address] unchanged.
// 5 Edges: count=0 -> done next cycle, no ram_load; count=100 -> exactly 64 writes;
//   words 16'hFFFF,16'h0002 -> checksum=16'h0001.
// 6 Abort: rst_n=0 after 2 of 5 beats -> IDLE, no done, first 2 words remain in RAM.

Source files
------------

// File: rtl/ram64_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram64_loader
// Description : Write stage in front of a 64x16 RAM. Passes CPU accesses
//               straight through when idle; on start it streams a block of
//               words from a valid/ready source into consecutive (wrapping)
//               RAM addresses, keeps a mod-2^16 checksum, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module ram64_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  base,
    input  logic [6:0]  count,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic [5:0]  cpu_address,
    input  logic [15:0] cpu_in,
    input  logic        cpu_load,
    output logic        cpu_stall,
    output logic [5:0]  ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_base;
    logic [5:0]  r_index;
    logic [6:0]  r_remaining;
    logic [15:0] r_checksum;
    logic [6:0]  w_count_sat;
    logic        w_beat;

    // A burst can never exceed the RAM depth, so oversize counts clamp to 64.
    assign w_count_sat = (count > 7'd64) ? 7'd64 : count;
    // in_ready is only high in LOAD, so a beat is a valid word during LOAD.
    assign w_beat      = (r_state == S_LOAD) && in_valid;
    assign checksum    = r_checksum;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and RAM port steering (CPU passthrough outside LOAD).
    always_comb begin
        w_next_state = r_state;
        ram_address  = cpu_address;
        ram_in       = cpu_in;
        ram_load     = cpu_load;
        busy         = 1'b0;
        in_ready     = 1'b0;
        cpu_stall    = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (count == 7'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                in_ready    = 1'b1;
                cpu_stall   = 1'b1;
                // 6-bit add wraps 63 -> 0 naturally.
                ram_address = r_base + r_index;
                ram_in      = in_data;
                ram_load    = in_valid;
                if (in_valid && (r_remaining == 7'd1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: capture on start, advance on every accepted word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= 6'd0;
            r_index     <= 6'd0;
            r_remaining <= 7'd0;
            r_checksum  <= 16'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_base      <= base;
            r_index     <= 6'd0;
            r_remaining <= w_count_sat;
            r_checksum  <= 16'd0;
        end else if (w_beat) begin
            r_index     <= r_index + 6'd1;
            r_remaining <= r_remaining - 7'd1;
            r_checksum  <= r_checksum + in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram64_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram64_loader
// Description : Self-checking bench for ram64_loader with a behavioural RAM
//               behind the DUT and a cycle reference model of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram64_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, cpu_load, cpu_stall;
    logic        ram_load, busy, done;
    logic [5:0]  base, cpu_address, ram_address;
    logic [6:0]  count;
    logic [15:0] in_data, cpu_in, ram_in, checksum;

    ram64_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_address(cpu_address), .cpu_in(cpu_in), .cpu_load(cpu_load),
        .cpu_stall(cpu_stall), .ram_address(ram_address), .ram_in(ram_in),
        .ram_load(ram_load), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // The RAM fed by the DUT.
    logic [15:0] ram [64] = '{default: 16'h0};
    always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

    // Event counters observed on the DUT outputs.
    int done_cnt = 0;
    int load_cnt = 0;
    always @(negedge clk) if (done) done_cnt++;
    always @(posedge clk) if (ram_load) load_cnt++;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 loading, 2 done.
    int          ms, mbase, midx, mrem;
    logic [15:0] msum;
    logic [15:0] mem [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [5:0]  ea;
        logic [15:0] ed;
        logic        el, eb, edn;
        @(negedge clk);
        if (ms == 1) begin
            ea = 6'((mbase + midx) % 64); ed = in_data; el = in_valid; eb = 1'b1;
        end else begin
            ea = cpu_address; ed = cpu_in; el = cpu_load; eb = 1'b0;
        end
        edn = (ms == 2);
        chk("outs", {37'd0, ram_address, ram_in, ram_load, busy, done, in_ready, cpu_stall},
                    {37'd0, ea, ed, el, eb, edn, eb, eb});
        chk("checksum", {48'd0, checksum}, {48'd0, msum});
        @(posedge clk);
        if (el) mem[ea] = ed;
        if (!rst_n) begin
            ms = 0; midx = 0; mrem = 0; msum = 16'd0; mbase = 0;
        end else begin
            case (ms)
                0: if (start) begin
                    mbase = base; midx = 0; msum = 16'd0;
                    mrem  = (count > 64) ? 64 : int'(count);
                    ms    = (count == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    msum = msum + in_data;
                    midx = midx + 1;
                    mrem = mrem - 1;
                    if (mrem == 0) ms = 2;
                end
                default: ms = 0;
            endcase
        end
        #1;
    endtask

    int          d0, l0;
    logic [15:0] saved;

    initial begin
        ms = 0; mbase = 0; midx = 0; mrem = 0; msum = 16'd0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        rst_n = 1'b0; start = 1'b1; base = 6'd0; count = 7'd5;
        in_valid = 1'b0; in_data = 16'h0;
        cpu_address = 6'd0; cpu_in = 16'h0; cpu_load = 1'b0;

        // Reset with start held high.
        #1; tick(); tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done_cnt", done_cnt, 0);

        // Passthrough write.
        rst_n = 1'b1; start = 1'b0;
        cpu_address = 6'd5; cpu_in = 16'h1234; cpu_load = 1'b1;
        tick();
        cpu_load = 1'b0;
        tick();
        chk("pass_ram5", ram[5], 16'h1234);

        // Back-to-back burst of three.
        d0 = done_cnt;
        base = 6'd10; count = 7'd3; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("burst_done_now", {63'd0, done}, 64'd1);
        tick();
        chk("burst_ram10", ram[10], 16'd1);
        chk("burst_ram11", ram[11], 16'd2);
        chk("burst_ram12", ram[12], 16'd3);
        chk("burst_sum", checksum, 16'd6);
        chk("burst_done_cnt", done_cnt - d0, 1);

        // Wrapping burst with gapped valid and blocked CPU writes.
        saved = ram[20];
        base = 6'd62; count = 7'd4; start = 1'b1;
        tick();
        start = 1'b0; cpu_address = 6'd20; cpu_in = 16'hBEEF; cpu_load = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'(100 + i);
            tick();
        end
        cpu_load = 1'b0; in_valid = 1'b0;
        tick();
        chk("wrap_ram62", ram[62], 16'd100);
        chk("wrap_ram63", ram[63], 16'd102);
        chk("wrap_ram0", ram[0], 16'd104);
        chk("wrap_ram1", ram[1], 16'd106);
        chk("wrap_cpu_blocked", ram[20], saved);

        // Zero-length burst.
        d0 = done_cnt; l0 = load_cnt;
        base = 6'd7; count = 7'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("cnt0_done", done_cnt - d0, 1);
        chk("cnt0_noload", load_cnt - l0, 0);

        // Oversize count saturates to 64 writes.
        d0 = done_cnt; l0 = load_cnt;
        base = 6'($urandom_range(0, 63)); count = 7'd100; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 70; i++) begin
            in_data = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("sat_loads", load_cnt - l0, 64);
        chk("sat_done", done_cnt - d0, 1);

        // Checksum carry discarded.
        base = 6'd40; count = 7'd2; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        in_data = 16'hFFFF; tick();
        in_data = 16'h0002; tick();
        in_valid = 1'b0;
        tick();
        chk("carry_sum", checksum, 16'h0001);

        // Reset mid-burst.
        d0 = done_cnt;
        base = 6'd30; count = 7'd5; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1;
        in_data = 16'hAAAA; tick();
        in_data = 16'hBBBB; tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("abort_nodone", done_cnt - d0, 0);
        chk("abort_ram30", ram[30], 16'hAAAA);
        chk("abort_ram31", ram[31], 16'hBBBB);
        chk("abort_busy", {63'd0, busy}, 64'd0);

        // Random bursts with random CPU traffic, gaps and ignored starts.
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                cpu_address = 6'($urandom); cpu_in = 16'($urandom); cpu_load = 1'($urandom);
                start = 1'b0;
                tick();
            end
            base  = 6'($urandom);
            count = (b % 7 == 6) ? 7'($urandom_range(65, 127)) : 7'($urandom_range(0, 12));
            start = 1'b1;
            for (int c = 0; c < 400 && (c == 0 || ms != 0); c++) begin
                cpu_address = 6'($urandom); cpu_in = 16'($urandom); cpu_load = 1'($urandom);
                in_valid = 1'($urandom); in_data = 16'($urandom);
                tick();
                start = 1'($urandom);
                base  = 6'($urandom);
                count = 7'($urandom);
            end
            start = 1'b0; cpu_load = 1'b0; in_valid = 1'b0;
            chk("rand_burst_end", {63'd0, busy}, 64'd0);
        end
        tick();

        for (int i = 0; i < 64; i++) chk("final_mem", ram[i], mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
